// File: rtl/census_pkg.sv
// Shared constants, pipeline stage type and BCD converter states for live_census.
package census_pkg;
  localparam int DEF_ROWS = 600;
  localparam int DEF_COLS = 25;

  function automatic int frame_blocks(input int rows, input int cols);
    return rows * cols;
  endfunction

  localparam int FRAME_BLOCKS = frame_blocks(DEF_ROWS, DEF_COLS);

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        valid;
  } stage_t;

  typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_DONE} bcd_state_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, b[i]};
    return c;
  endfunction
endpackage

// File: rtl/popcount32.sv
// Registered 32-bit popcount (one cycle) that carries the block's last/valid flags alongside.
module popcount32
  import census_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_flush,
  input  logic [31:0] i_data,
  input  logic        i_last,
  input  logic        i_valid,
  output logic [5:0]  o_cnt,
  output logic        o_last,
  output logic        o_valid
);
  logic [5:0] w_sum;

  assign w_sum = {2'b00, popcnt8(i_data[7:0])}   + {2'b00, popcnt8(i_data[15:8])}
               + {2'b00, popcnt8(i_data[23:16])} + {2'b00, popcnt8(i_data[31:24])};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_cnt   <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_cnt   <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_cnt   <= w_sum;
      o_last  <= i_last;
      o_valid <= i_valid;
    end
  end
endmodule

// File: rtl/live_census.sv
// Snoops the evolution engine write stream and reports per-generation population,
// generation count, extinction and still-life. Define CENSUS_BCD_EN for a BCD population output.
module live_census
  import census_pkg::*;
#(
  parameter int P_PARAM_M   = 600,
  parameter int READ_COL    = 25,
  parameter int BLOCK_LEN   = 32,
  parameter int STABLE_GENS = 4,
  parameter int POP_W       = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [23:0]          wr_addr,
  input  logic [BLOCK_LEN-1:0] wr_data,
  output logic [POP_W-1:0]     population,
  output logic [15:0]          generation,
  output logic                 frame_done,
  output logic                 extinct,
  output logic                 stable,
  output logic                 seq_err
`ifdef CENSUS_BCD_EN
  ,
  output logic [31:0]          pop_bcd,
  output logic                 bcd_valid
`endif
);
  localparam int          FB       = frame_blocks(P_PARAM_M, READ_COL);
  localparam logic [23:0] LAST_BLK = 24'(FB - 1);
  localparam int          SW       = $clog2(STABLE_GENS + 1);

  // Stage 0: capture block, track block counter / expected address
  stage_t      r_s0;
  logic [23:0] r_blk;
  logic        w_last;

  assign w_last = (r_blk == LAST_BLK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0    <= '0;
      r_blk   <= '0;
      seq_err <= 1'b0;
    end else if (clear) begin
      r_s0    <= '0;
      r_blk   <= '0;
      seq_err <= 1'b0;
    end else begin
      r_s0 <= '{data: wr_data, last: wr_en & w_last, valid: wr_en};
      if (wr_en) begin
        r_blk <= w_last ? '0 : r_blk + 24'd1;
        if (wr_addr != r_blk) seq_err <= 1'b1;
      end
    end
  end

  // Stage 1: popcount
  logic [5:0] w_cnt;
  logic       w_s1_last, w_s1_vld;

  popcount32 u_pop (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (clear),
    .i_data  (r_s0.data),
    .i_last  (r_s0.last),
    .i_valid (r_s0.valid),
    .o_cnt   (w_cnt),
    .o_last  (w_s1_last),
    .o_valid (w_s1_vld)
  );

  // Stage 2: accumulate; frame total is handed to the output stage on the last block
  logic [POP_W-1:0] r_acc, r_tot, w_acc_next;
  logic             r_tot_vld;

  assign w_acc_next = r_acc + POP_W'(w_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_tot     <= '0;
      r_tot_vld <= 1'b0;
    end else if (clear) begin
      r_acc     <= '0;
      r_tot     <= '0;
      r_tot_vld <= 1'b0;
    end else begin
      r_tot_vld <= w_s1_vld & w_s1_last;
      if (w_s1_vld) begin
        if (w_s1_last) begin
          r_acc <= '0;
          r_tot <= w_acc_next;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  // Stage 3: published statistics
  logic [SW-1:0] r_stab_cnt, w_stab_nxt;
  logic          r_have_prev, w_match;

  assign w_match = r_have_prev && (r_tot == population);

  always_comb begin
    w_stab_nxt = '0;
    if (w_match)
      w_stab_nxt = (r_stab_cnt == SW'(STABLE_GENS)) ? r_stab_cnt : r_stab_cnt + SW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      population  <= '0;
      generation  <= '0;
      frame_done  <= 1'b0;
      extinct     <= 1'b0;
      stable      <= 1'b0;
      r_stab_cnt  <= '0;
      r_have_prev <= 1'b0;
    end else if (clear) begin
      population  <= '0;
      generation  <= '0;
      frame_done  <= 1'b0;
      extinct     <= 1'b0;
      stable      <= 1'b0;
      r_stab_cnt  <= '0;
      r_have_prev <= 1'b0;
    end else begin
      frame_done <= r_tot_vld;
      if (r_tot_vld) begin
        population  <= r_tot;
        generation  <= (generation == 16'hFFFF) ? generation : generation + 16'd1;
        extinct     <= (r_tot == '0);
        r_stab_cnt  <= w_stab_nxt;
        stable      <= (w_stab_nxt == SW'(STABLE_GENS));
        r_have_prev <= 1'b1;
      end
    end
  end

`ifdef CENSUS_BCD_EN
  // Double-dabble, one shift per cycle; the first shift happens on the load cycle
  localparam int CW = $clog2(POP_W + 1);

  bcd_state_e       r_bcd_st, w_bcd_st_nxt;
  logic [POP_W-1:0] r_bin;
  logic [31:0]      r_bcd, w_adj, w_bcd_sh;
  logic [CW-1:0]    r_shcnt;

  always_comb begin
    w_adj = '0;
    for (int d = 0; d < 8; d++)
      w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3 : r_bcd[4*d +: 4];
  end

  assign w_bcd_sh = {w_adj[30:0], r_bin[POP_W-1]};

  always_comb begin
    w_bcd_st_nxt = r_bcd_st;
    bcd_valid    = (r_bcd_st == BCD_DONE);
    if (frame_done)
      w_bcd_st_nxt = BCD_SHIFT;
    else if (r_bcd_st == BCD_SHIFT && r_shcnt == CW'(POP_W - 1))
      w_bcd_st_nxt = BCD_DONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd_st <= BCD_IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_shcnt  <= '0;
      pop_bcd  <= '0;
    end else begin
      r_bcd_st <= w_bcd_st_nxt;
      if (frame_done) begin
        r_bcd   <= {31'd0, population[POP_W-1]};
        r_bin   <= population << 1;
        r_shcnt <= CW'(1);
      end else if (r_bcd_st == BCD_SHIFT) begin
        r_bcd   <= w_bcd_sh;
        r_bin   <= r_bin << 1;
        r_shcnt <= r_shcnt + CW'(1);
        if (r_shcnt == CW'(POP_W - 1)) pop_bcd <= w_bcd_sh;
      end
    end
  end
`endif
endmodule

// File: tb/tb_live_census.sv
// Directed bench: one default-size instance for full-frame checks, one 50-block instance for the rest.
module tb_live_census;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear = 1'b0;
  logic        en_f = 1'b0, en_s = 1'b0;
  logic [23:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [19:0] pop_f, pop_s;
  logic [15:0] gen_f, gen_s;
  logic        fd_f, fd_s, ext_f, ext_s, stb_f, stb_s, se_f, se_s;
`ifdef CENSUS_BCD_EN
  logic [31:0] bcd_f, bcd_s;
  logic        bv_f, bv_s;
`endif
  int checks = 0;
  int errors = 0;
  int lat, np;

  always #5 clk = ~clk;

  live_census u_full (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(en_f), .wr_addr(wr_addr),
    .wr_data(wr_data), .population(pop_f), .generation(gen_f), .frame_done(fd_f),
    .extinct(ext_f), .stable(stb_f), .seq_err(se_f)
`ifdef CENSUS_BCD_EN
    , .pop_bcd(bcd_f), .bcd_valid(bv_f)
`endif
  );

  live_census #(.P_PARAM_M(2)) u_small (
    .clk(clk), .reset_n(reset_n), .clear(clear), .wr_en(en_s), .wr_addr(wr_addr),
    .wr_data(wr_data), .population(pop_s), .generation(gen_s), .frame_done(fd_s),
    .extinct(ext_s), .stable(stb_s), .seq_err(se_s)
`ifdef CENSUS_BCD_EN
    , .pop_bcd(bcd_s), .bcd_valid(bv_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_blk(input bit full, input int a, input logic [31:0] d);
    @(negedge clk);
    en_f    = full;
    en_s    = !full;
    wr_addr = 24'(a);
    wr_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en_f = 1'b0;
      en_s = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    en_f = 1'b0; en_s = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // modes: 0 zeros, 1 ones, 2 single 0x80000001 at 7 with gaps, 3 ones-bit with address 5 skipped, 4 123456 cells
  task automatic send_frame(input bit full, input int n, input int mode);
    logic [31:0] d;
    int a;
    for (int i = 0; i < n; i++) begin
      a = i;
      case (mode)
        1:       d = 32'hFFFF_FFFF;
        2:       d = (i == 7) ? 32'h8000_0001 : 32'h0;
        3:       begin d = 32'h1; a = (i == 5) ? 6 : i; end
        4:       d = (i < 3858) ? 32'hFFFF_FFFF : 32'h0;
        default: d = 32'h0;
      endcase
      if (mode == 2 && i != 0) idle($urandom_range(0, 2));
      write_blk(full, a, d);
    end
  endtask

  // Observes 10 negedges after the final write; lat is the first negedge index showing frame_done.
  task automatic finish_frame(input bit full, input int clr_at, output int lat_o, output int np_o);
    lat_o = -1;
    np_o  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      en_f  = 1'b0;
      en_s  = 1'b0;
      clear = (i == clr_at);
      if (full ? fd_f : fd_s) begin
        np_o++;
        if (lat_o < 0) lat_o = i;
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pop", pop_s, 0);
    chk("rst_gen", gen_s, 0);
    chk("rst_fd", fd_s, 0);
    chk("rst_ext", ext_s, 0);
    chk("rst_stb", stb_s, 0);
    chk("rst_seq", se_s, 0);
    chk("rst_pop_full", pop_f, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

`ifdef CENSUS_BCD_EN
    chk("rst_bcd", bcd_f, 0);
    chk("rst_bv", bv_f, 0);
    send_frame(1'b1, 15000, 4);
    finish_frame(1'b1, 0, lat, np);
    chk("bcd_frame_pop", pop_f, 123456);
    begin
      int k;
      k = -1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (bv_f && k < 0) k = i;
      end
      // frame_done seen at index 4 of finish_frame; 20 cycles later is 14 negedges past its end
      chk("bcd_latency", k, 14);
    end
    chk("bcd_value", bcd_f, 32'h0012_3456);
    pulse_clear();
    chk("bcd_clear_gen", gen_f, 0);
`endif

    // Full-size frame of all-live blocks
    send_frame(1'b1, 15000, 1);
    finish_frame(1'b1, 0, lat, np);
    chk("full_lat", lat, 4);
    chk("full_pulses", np, 1);
    chk("full_pop", pop_f, 480000);
    chk("full_gen", gen_f, 1);
    chk("full_ext", ext_f, 0);
    chk("full_seq", se_f, 0);

`ifdef CENSUS_BCD_EN
    chk("bcd_busy_bv", bv_f, 0);
    chk("bcd_busy_val", bcd_f, 32'h0012_3456);
    reset_n = 1'b0;
    #1;
    chk("bcd_rst_val", bcd_f, 0);
    chk("bcd_rst_bv", bv_f, 0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    // Five all-dead frames: stable only after the fifth
    for (int g = 1; g <= 5; g++) begin
      send_frame(1'b0, 50, 0);
      finish_frame(1'b0, 0, lat, np);
      chk($sformatf("dead_stable_g%0d", g), stb_s, (g == 5));
      chk($sformatf("dead_ext_g%0d", g), ext_s, 1);
    end
    chk("dead_gen", gen_s, 5);
    chk("dead_pop", pop_s, 0);

    // Sparse frame with idle gaps
    pulse_clear();
    chk("clr_gen", gen_s, 0);
    chk("clr_stable", stb_s, 0);
    chk("clr_ext", ext_s, 0);
    send_frame(1'b0, 50, 2);
    finish_frame(1'b0, 0, lat, np);
    chk("sparse_lat", lat, 4);
    chk("sparse_pop", pop_s, 2);
    chk("sparse_gen", gen_s, 1);
    chk("sparse_ext", ext_s, 0);
    chk("sparse_stable", stb_s, 0);

    // clear landing on the final stage beats frame_done
    send_frame(1'b0, 50, 1);
    finish_frame(1'b0, 3, lat, np);
    chk("clrlast_pulses", np, 0);
    chk("clrlast_gen", gen_s, 0);
    chk("clrlast_pop", pop_s, 0);
    send_frame(1'b0, 50, 1);
    finish_frame(1'b0, 0, lat, np);
    chk("after_clr_gen", gen_s, 1);
    chk("after_clr_pop", pop_s, 1600);
    chk("after_clr_lat", lat, 4);

    // Skipped address
    pulse_clear();
    send_frame(1'b0, 10, 3);
    chk("skip_seq_mid", se_s, 1);
    send_frame(1'b0, 40, 0);
    finish_frame(1'b0, 0, lat, np);
    chk("skip_seq_done", se_s, 1);
    chk("skip_pulses", np, 1);
    chk("skip_pop", pop_s, 10);
    pulse_clear();
    chk("skip_seq_clr", se_s, 0);

    // Reset mid-frame discards the partial count
    send_frame(1'b0, 20, 1);
    @(negedge clk);
    en_s = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_frame(1'b0, 50, 1);
    finish_frame(1'b0, 0, lat, np);
    chk("rstmid_pop", pop_s, 1600);
    chk("rstmid_gen", gen_s, 1);
    chk("rstmid_seq", se_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/live_census.md
Name: live_census

Overview:
- Statistics stage directly downstream of the evolution engine.
- Snoops the evolution engine's write stream (wden / write address / 32-bit live block) and counts live cells per generation.
- Tracks the generation number and detects extinction and still-life states.
- Feeds the seven-segment display number and the debug LEDs. It never touches the frame RAMs.

Parameters:
- P_PARAM_M, 600, screen rows
- READ_COL, 25, blocks per row
- BLOCK_LEN, 32, cells per block; fixed at 32, other values unsupported
- STABLE_GENS, 4, consecutive unchanged generations before stable asserts
- POP_W, 20, population width; must be at least clog2(M*N+1)

Ports:
- clk  in  1  pixel clock (50 MHz)
- reset_n  in  1  asynchronous reset, active low
- clear  in  1  synchronous restart pulse (game cleared or new preset)
- wr_en  in  1  evolution-engine write enable; one block per asserted cycle
- wr_addr  in  24  evolution-engine write address
- wr_data  in  32  evolution-engine write data; bit = 1 means live cell
- population  out  POP_W  live-cell count of the last completed generation
- generation  out  16  completed-generation count
- frame_done  out  1  one-cycle pulse when population/generation update
- extinct  out  1  last completed population == 0
- stable  out  1  population unchanged for STABLE_GENS consecutive generations
- seq_err  out  1  sticky: wr_addr differed from expected address

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; accumulator, expected address and block counter 0; pipeline valids 0.
- Frame size: FRAME_BLOCKS = P_PARAM_M * READ_COL (15000 by default). Write addresses are sequential 0..FRAME_BLOCKS-1.
- Stage 0: on wr_en, wr_data is registered together with a last flag. last = (block counter == FRAME_BLOCKS-1).
  - Block counter increments on each write and wraps to 0 after the last block.
  - Expected address follows the block counter. If wr_addr != expected, seq_err sets; it clears only on reset or clear.
- Stage 1: four 8-bit popcounts are summed to 0..32 (6 bits).
- Stage 2: the sum is added to the accumulator. When the last flag is set:
  - population <= accumulator + sum, and the accumulator resets to 0 in the same cycle.
  - generation increments, saturating at 16'hFFFF.
  - frame_done pulses for one cycle.
- Latency: frame_done, population and generation update on the third rising edge after the edge that samples the final wr_en.
- Back-to-back writes are supported every cycle with no stalls. Idle cycles between writes are allowed and do not affect counting.
- extinct updates together with population: 1 iff the new population == 0.
- stable counter logic:
  - Counter increments (saturating at STABLE_GENS) when the new population equals the previous population; otherwise it resets to 0.
  - stable = (counter == STABLE_GENS).
  - The first generation after reset or clear never counts as a match.
- clear (synchronous):
  - Flushes pipeline valids; zeroes the accumulator, block counter, generation, population, extinct, stable and seq_err.
  - If clear coincides with an in-flight last block, clear wins: no frame_done.
- Writes arriving in the same cycle as clear are discarded.
- Reset mid-frame discards the partial count. Counting restarts from block 0.
- Accumulator maximum is FRAME_BLOCKS*32 (480000), which fits POP_W = 20 with no overflow.

Optional Feature:
- Macro: CENSUS_BCD_EN.
- When defined:
  - Adds output pop_bcd [31:0]: population as 8 BCD digits (upper digits 0), plus bcd_valid [1].
  - Conversion is a sequential double-dabble: one shift per cycle, 20 cycles.
  - Conversion starts on frame_done. bcd_valid drops while converting and rises when the result latches.
  - A new frame_done during conversion restarts the conversion with the newer value.
  - Reset: pop_bcd = 0, bcd_valid = 0.
- When undefined: neither port exists and no conversion logic is built.

Decomposition:
- Package census_pkg holds:
  - FRAME_BLOCKS as a localparam function of M and READ_COL.
  - The pipeline stage struct typedef: data, last, valid.
  - The BCD state enum: BCD_IDLE, BCD_SHIFT, BCD_DONE.
- One sub-module, popcount32: registered 32-bit popcount with 1-cycle latency and 6-bit output. It implements stage 1.

Test Plan:
- 15000 consecutive writes of 32'hFFFFFFFF, addresses 0..14999 -> population = 480000, generation = 1, frame_done once, extinct = 0, seq_err = 0.
- Full frame of all-zero blocks, repeated 5 times -> extinct = 1; stable = 1 after the 5th frame_done (4 unchanged generations), 0 before.
- Single block 32'h8000_0001 at address 7, zeros elsewhere, with random idle gaps between writes -> population = 2, with latency exactly 3 edges after the final write.
- clear asserted on the cycle the last block's stage-2 result would land -> no frame_done; generation = 0; the next full frame gives generation = 1.
- Address 5 skipped (write to 6 where 5 is expected) -> seq_err = 1 and stays set through frame_done; clear -> seq_err = 0.
- CENSUS_BCD_EN, population 123456 -> bcd_valid rises 20 cycles after frame_done with pop_bcd = 32'h00123456; reset_n pulled low mid-conversion -> pop_bcd = 0, bcd_valid = 0.
